text_renderer: RTL and testbench

- Text-mode pixel stage that sits directly downstream of the VGA timing generator.
- Consumes the generator's h_counter, v_counter, can_color, hsync and vsync, and produces 12-bit RGB for the DAC pins.
- Fetches character/attribute words from an external synchronous character RAM and glyph rows from an external synchronous font ROM.
- Renders an 8x16-cell, 180x56 text screen inside the 1440x900 active area, with a blinking underline cursor.
- Delays the sync signals to match the pixel pipeline latency.

---
 rtl/text_renderer_if.sv | 33 +++
 rtl/text_renderer.sv | 145 ++++++++++++++
 tb/tb_text_renderer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_renderer_if.sv
// Video-side bundle for the text renderer: timing-generator inputs, cursor
// controls, character RAM / font ROM read ports and the DAC-facing outputs.
interface text_renderer_if;
    logic [10:0] h_counter;
    logic [9:0]  v_counter;
    logic        can_color;
    logic        hsync_in;
    logic        vsync_in;
    logic        cursor_en;
    logic [7:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [13:0] char_addr;
    logic [15:0] char_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        de;

    // The renderer is the master: it issues memory addresses and drives the DAC.
    modport master (
        input  h_counter, v_counter, can_color, hsync_in, vsync_in,
        input  cursor_en, cursor_col, cursor_row, char_data, font_data,
        output char_addr, font_addr, rgb, hsync_out, vsync_out, de
    );

    modport slave (
        output h_counter, v_counter, can_color, hsync_in, vsync_in,
        output cursor_en, cursor_col, cursor_row, char_data, font_data,
        input  char_addr, font_addr, rgb, hsync_out, vsync_out, de
    );
endinterface

// File: rtl/text_renderer.sv
// Text-mode pixel stage: 8x16 glyph cells on a 180x56 grid, five-cycle pipeline
// through character RAM and font ROM, blinking underline cursor, delayed syncs.
module text_renderer #(
    parameter int COLS      = 180,
    parameter int ROWS      = 56,
    parameter int BLINK_BIT = 5
) (
    input  logic            clk,
    input  logic            rst,
    text_renderer_if.master io_bus
);

    typedef struct packed {
        logic [2:0] bitsel;
        logic       de;
        logic       hit;
        logic       blank;
    } side_t;

    logic [7:0]  w_col;
    logic [5:0]  w_row;
    logic [5:0]  w_row_clamp;
    logic [3:0]  w_line;
    logic        w_blank_row;
    logic        w_hit;
    logic [13:0] w_char_addr;
    logic        w_font_bit;
    logic        w_pix;
    logic [3:0]  w_color_idx;

    logic [13:0] r_char_addr;
    logic [11:0] r_font_addr;
    logic [5:0]  r_frame_cnt;
    logic        r_vs_prev;
    side_t       r_side [1:4];
    logic [3:0]  r_line1;
    logic [3:0]  r_line2;
    logic [3:0]  r_fg3;
    logic [3:0]  r_bg3;
    logic [3:0]  r_fg4;
    logic [3:0]  r_bg4;
    logic [4:0]  r_hs_dly;
    logic [4:0]  r_vs_dly;
    logic [11:0] r_rgb;
    logic        r_de;

    function automatic logic [11:0] palette(input logic [3:0] idx);
        logic [11:0] c;
        c = 12'h000;
        case (idx)
            4'd0:  c = 12'h000;
            4'd1:  c = 12'h00A;
            4'd2:  c = 12'h0A0;
            4'd3:  c = 12'h0AA;
            4'd4:  c = 12'hA00;
            4'd5:  c = 12'hA0A;
            4'd6:  c = 12'hA50;
            4'd7:  c = 12'hAAA;
            4'd8:  c = 12'h555;
            4'd9:  c = 12'h55F;
            4'd10: c = 12'h5F5;
            4'd11: c = 12'h5FF;
            4'd12: c = 12'hF55;
            4'd13: c = 12'hF5F;
            4'd14: c = 12'hFF5;
            4'd15: c = 12'hFFF;
        endcase
        return c;
    endfunction

    // Stage 0: decode the raw counters into cell coordinates.
    assign w_col       = io_bus.h_counter[10:3];
    assign w_row       = io_bus.v_counter[9:4];
    assign w_line      = io_bus.v_counter[3:0];
    assign w_blank_row = (w_row >= 6'(ROWS));
    assign w_row_clamp = w_blank_row ? 6'(ROWS - 1) : w_row;
    // Constant multiply by 180 reduces to row*128 + row*32 + row*16 + row*4.
    assign w_char_addr = 14'(w_row_clamp) * 14'(COLS) + 14'(w_col);
    assign w_hit       = io_bus.cursor_en
                       & (w_col == io_bus.cursor_col)
                       & (w_row == io_bus.cursor_row)
                       & (w_line >= 4'd14)
                       & r_frame_cnt[BLINK_BIT];

    // Stage 4 -> 5: glyph bit, cursor inversion, bottom-band blanking.
    assign w_font_bit  = io_bus.font_data[3'd7 - r_side[4].bitsel];
    assign w_pix       = ~r_side[4].blank & (w_font_bit ^ r_side[4].hit);
    assign w_color_idx = w_pix ? r_fg4 : r_bg4;

    // NOTE: every register in this block uses <= so each stage samples the
    // previous stage's value from before the edge; blocking '=' would collapse the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_char_addr <= '0;
            r_font_addr <= '0;
            r_frame_cnt <= '0;
            r_vs_prev   <= 1'b0;
            for (int i = 1; i <= 4; i++) r_side[i] <= '0;
            r_line1     <= '0;
            r_line2     <= '0;
            r_fg3       <= '0;
            r_bg3       <= '0;
            r_fg4       <= '0;
            r_bg4       <= '0;
            r_hs_dly    <= '1;
            r_vs_dly    <= '0;
            r_rgb       <= '0;
            r_de        <= 1'b0;
        end else begin
            r_vs_prev <= io_bus.vsync_in;
            if (io_bus.vsync_in & ~r_vs_prev)
                r_frame_cnt <= r_frame_cnt + 6'd1;

            r_char_addr <= w_char_addr;
            r_side[1]   <= '{bitsel: io_bus.h_counter[2:0], de: io_bus.can_color,
                             hit: w_hit, blank: w_blank_row};
            r_line1     <= w_line;
            r_side[2]   <= r_side[1];
            r_line2     <= r_line1;

            // char_data now answers the address issued two edges ago.
            r_font_addr <= {io_bus.char_data[7:0], r_line2};
            r_fg3       <= io_bus.char_data[11:8];
            r_bg3       <= r_side[2].blank ? 4'd0 : io_bus.char_data[15:12];
            r_side[3]   <= r_side[2];

            r_fg4       <= r_fg3;
            r_bg4       <= r_bg3;
            r_side[4]   <= r_side[3];

            r_rgb       <= r_side[4].de ? palette(w_color_idx) : 12'h000;
            r_de        <= r_side[4].de;
            r_hs_dly    <= {r_hs_dly[3:0], io_bus.hsync_in};
            r_vs_dly    <= {r_vs_dly[3:0], io_bus.vsync_in};
        end
    end

    assign io_bus.char_addr = r_char_addr;
    assign io_bus.font_addr = r_font_addr;
    assign io_bus.rgb       = r_rgb;
    assign io_bus.de        = r_de;
    assign io_bus.hsync_out = r_hs_dly[4];
    assign io_bus.vsync_out = r_vs_dly[4];

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench for text_renderer: table vectors, hand sequences for
// latency/cursor/reset, and random stimulus against a cell-level reference model.
module tb_text_renderer;

    localparam int MAXS = 8192;
    localparam logic [11:0] PAL [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic [13:0] ca;
        logic [11:0] fa;
    } snap_t;

    typedef struct {
        int          h;
        int          v;
        bit          cc;
        logic [13:0] ca;
        logic [11:0] fa;
        logic [11:0] rgb;
    } vec_t;

    logic clk;
    logic rst;
    text_renderer_if bus ();

    text_renderer #(.COLS(180), .ROWS(56), .BLINK_BIT(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.master)
    );

    logic [15:0] char_ram [16384];
    logic [7:0]  font_rom [4096];

    snap_t       snaps   [MAXS];
    logic [11:0] exp_rgb [MAXS];
    logic        exp_hs  [MAXS];
    logic        exp_vs  [MAXS];
    logic        exp_de  [MAXS];
    logic [13:0] exp_ca  [MAXS];
    vec_t        vecs    [13];

    int n_checks;
    int n_fail;
    int step_no;
    int frames;
    bit vprev;
    int gen_h;
    int gen_v;
    int ks, kc, kr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories: one cycle of read latency.
    always @(posedge clk) begin
        bus.char_data <= char_ram[bus.char_addr];
        bus.font_data <= font_rom[bus.font_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, expv);
        end
    endtask

    function automatic logic [11:0] model_rgb(input int h, input int v, input bit cc,
                                              input bit cen, input int ccol, input int crow,
                                              input int fr);
        int          row, col, gl;
        logic [15:0] w;
        logic [7:0]  f;
        bit          b, hit;
        if (!cc) return 12'h000;
        row = v / 16;
        col = h / 8;
        gl  = v % 16;
        if (row >= 56) return 12'h000;
        w   = char_ram[row * 180 + col];
        f   = font_rom[{w[7:0], 4'(gl)}];
        b   = f[7 - (h % 8)];
        hit = cen && (col == ccol) && (row == crow) && (gl >= 14) && ((fr % 64) >= 32);
        return (b ^ hit) ? PAL[w[11:8]] : PAL[w[15:12]];
    endfunction

    // One clock: sample outputs, score them, then drive the next inputs.
    task automatic step(input bit r, input int h, input int v, input bit cc, input bit hs,
                        input bit vs, input bit cen, input int ccol, input int crow);
        int row;
        @(negedge clk);
        if (step_no >= MAXS) begin
            $display("FAIL step budget: actual %0d, required below %0d", step_no, MAXS);
            $fatal(1);
        end
        snaps[step_no] = '{bus.rgb, bus.hsync_out, bus.vsync_out, bus.de,
                           bus.char_addr, bus.font_addr};
        if (step_no >= 5) begin
            check($sformatf("rgb@%0d", step_no), 32'(snaps[step_no].rgb), 32'(exp_rgb[step_no-5]));
            check($sformatf("hsync@%0d", step_no), 32'(snaps[step_no].hs), 32'(exp_hs[step_no-5]));
            check($sformatf("vsync@%0d", step_no), 32'(snaps[step_no].vs), 32'(exp_vs[step_no-5]));
            check($sformatf("de@%0d", step_no), 32'(snaps[step_no].de), 32'(exp_de[step_no-5]));
        end
        if (step_no >= 1)
            check($sformatf("char_addr@%0d", step_no), 32'(snaps[step_no].ca), 32'(exp_ca[step_no-1]));

        rst            = r;
        bus.h_counter  = 11'(h);
        bus.v_counter  = 10'(v);
        bus.can_color  = cc;
        bus.hsync_in   = hs;
        bus.vsync_in   = vs;
        bus.cursor_en  = cen;
        bus.cursor_col = 8'(ccol);
        bus.cursor_row = 6'(crow);

        if (r) begin
            // Anything still in flight is flushed by reset.
            for (int j = step_no - 4; j <= step_no; j++) begin
                if (j >= 0) begin
                    exp_rgb[j] = 12'h000;
                    exp_hs[j]  = 1'b1;
                    exp_vs[j]  = 1'b0;
                    exp_de[j]  = 1'b0;
                end
            end
            exp_ca[step_no] = 14'd0;
            frames = 0;
            vprev  = 1'b0;
        end else begin
            exp_rgb[step_no] = model_rgb(h, v, cc, cen, ccol, crow, frames);
            exp_hs[step_no]  = hs;
            exp_vs[step_no]  = vs;
            exp_de[step_no]  = cc;
            row = (v / 16 > 55) ? 55 : v / 16;
            exp_ca[step_no]  = 14'(row * 180 + h / 8);
            if (vs && !vprev) frames++;
            vprev = vs;
        end
        step_no++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1500, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic gen_step(input bit r);
        step(r, gen_h, gen_v, (gen_h < 1440) && (gen_v < 900),
             !((gen_h >= 1520) && (gen_h < 1672)), (gen_v >= 901) && (gen_v < 904),
             1'b0, 0, 0);
        gen_h++;
        if (gen_h == 1904) begin
            gen_h = 0;
            gen_v = (gen_v == 931) ? 0 : gen_v + 1;
        end
    endtask

    task automatic pulse_vsync(input int n);
        repeat (n) begin
            step(1'b0, 0, 905, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
            step(1'b0, 0, 905, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        end
    endtask

    // Cursor at column 3, row 2: lines 46/47 hit, line 45 never does.
    task automatic cursor_phase(input logic [11:0] on_rgb, input string tag);
        int k0;
        int lines [3];
        lines[0] = 46;
        lines[1] = 47;
        lines[2] = 45;
        k0 = step_no;
        for (int li = 0; li < 3; li++)
            for (int x = 24; x < 32; x++)
                step(1'b0, x, lines[li], 1'b1, 1'b1, 1'b0, 1'b1, 3, 2);
        idle(5);
        for (int li = 0; li < 3; li++)
            for (int x = 24; x < 32; x++)
                check($sformatf("cursor %s line %0d h %0d", tag, lines[li], x),
                      32'(snaps[k0 + li * 8 + (x - 24) + 5].rgb),
                      32'((li < 2) ? on_rgb : 12'h000));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        step_no  = 0;
        frames   = 0;
        vprev    = 1'b0;
        rst            = 1'b1;
        bus.h_counter  = '0;
        bus.v_counter  = '0;
        bus.can_color  = 1'b0;
        bus.hsync_in   = 1'b1;
        bus.vsync_in   = 1'b0;
        bus.cursor_en  = 1'b0;
        bus.cursor_col = '0;
        bus.cursor_row = '0;

        for (int i = 0; i < 16384; i++) char_ram[i] = 16'h0000;
        for (int i = 0; i < 4096; i++)  font_rom[i] = 8'h00;
        char_ram[0]     = 16'h1F41;
        char_ram[181]   = 16'h4C41;
        char_ram[363]   = 16'h0F00;
        char_ram[9900]  = 16'hFF20;
        char_ram[10079] = 16'h3A7E;
        font_rom[12'h410] = 8'h18;
        font_rom[12'h411] = 8'h24;
        font_rom[12'h200] = 8'hFF;
        font_rom[12'h7EF] = 8'h01;

        vecs[0]  = '{0,    0,   1'b1, 14'd0,     12'h410, 12'h00A};
        vecs[1]  = '{1,    0,   1'b1, 14'd0,     12'h410, 12'h00A};
        vecs[2]  = '{2,    0,   1'b1, 14'd0,     12'h410, 12'h00A};
        vecs[3]  = '{3,    0,   1'b1, 14'd0,     12'h410, 12'hFFF};
        vecs[4]  = '{4,    0,   1'b1, 14'd0,     12'h410, 12'hFFF};
        vecs[5]  = '{5,    0,   1'b1, 14'd0,     12'h410, 12'h00A};
        vecs[6]  = '{6,    0,   1'b1, 14'd0,     12'h410, 12'h00A};
        vecs[7]  = '{7,    0,   1'b1, 14'd0,     12'h410, 12'h00A};
        vecs[8]  = '{1439, 895, 1'b1, 14'd10079, 12'h7EF, 12'h5F5};
        vecs[9]  = '{0,    896, 1'b1, 14'd9900,  12'h200, 12'h000};
        vecs[10] = '{1439, 899, 1'b1, 14'd10079, 12'h7E3, 12'h000};
        vecs[11] = '{3,    0,   1'b0, 14'd0,     12'h410, 12'h000};
        vecs[12] = '{13,   17,  1'b1, 14'd181,   12'h411, 12'hF55};

        // Reset for two cycles, then run the timing generator across hsync and line wrap.
        gen_h = 1500;
        gen_v = 0;
        gen_step(1'b1);
        gen_step(1'b1);
        ks = -1;
        kc = -1;
        while (!(gen_h == 10 && gen_v == 1)) begin
            if (gen_h == 1520 && gen_v == 0) ks = step_no;
            if (gen_h == 0 && gen_v == 1)    kc = step_no;
            gen_step(1'b0);
        end
        idle(5);

        check("reset rgb",       32'(snaps[1].rgb), 32'h000);
        check("reset de",        32'(snaps[1].de),  32'h0);
        check("reset hsync_out", 32'(snaps[1].hs),  32'h1);
        check("reset vsync_out", 32'(snaps[1].vs),  32'h0);
        check("reset char_addr", 32'(snaps[1].ca),  32'h0);
        check("reset font_addr", 32'(snaps[1].fa),  32'h0);
        check("hsync_out before fall", 32'(snaps[ks + 4].hs), 32'h1);
        check("hsync_out fall at +5",  32'(snaps[ks + 5].hs), 32'h0);
        check("de before rise",        32'(snaps[kc + 4].de), 32'h0);
        check("de rise at +5",         32'(snaps[kc + 5].de), 32'h1);

        for (int i = 0; i < 13; i++) begin
            int k;
            k = step_no;
            step(1'b0, vecs[i].h, vecs[i].v, vecs[i].cc, 1'b1, 1'b0, 1'b0, 0, 0);
            idle(5);
            check($sformatf("vec%0d char_addr", i), 32'(snaps[k + 1].ca),  32'(vecs[i].ca));
            check($sformatf("vec%0d font_addr", i), 32'(snaps[k + 3].fa),  32'(vecs[i].fa));
            check($sformatf("vec%0d rgb", i),       32'(snaps[k + 5].rgb), 32'(vecs[i].rgb));
        end

        // Blink: off for frames 0..31, on for 32..63, off again after the wrap.
        cursor_phase(12'h000, "f0");
        pulse_vsync(31);
        cursor_phase(12'h000, "f31");
        pulse_vsync(1);
        cursor_phase(12'hFFF, "f32");
        pulse_vsync(31);
        cursor_phase(12'hFFF, "f63");
        pulse_vsync(1);
        cursor_phase(12'h000, "f64");

        // Mid-frame reset with blink on beforehand; the frame counter must clear.
        for (int i = 0; i < 16384; i++) char_ram[i] = 16'($urandom);
        for (int i = 0; i < 4096; i++)  font_rom[i] = 8'($urandom);
        char_ram[363] = 16'h0F00;
        for (int i = 0; i < 16; i++) font_rom[i] = 8'h00;
        pulse_vsync(32);
        gen_h = 650;
        gen_v = 300;
        kr = -1;
        while (gen_h <= 760) begin
            if (gen_h == 700) kr = step_no;
            gen_step(gen_h == 700);
        end
        idle(5);
        check("midreset rgb",       32'(snaps[kr + 1].rgb), 32'h000);
        check("midreset de",        32'(snaps[kr + 1].de),  32'h0);
        check("midreset hsync_out", 32'(snaps[kr + 1].hs),  32'h1);
        check("midreset vsync_out", 32'(snaps[kr + 1].vs),  32'h0);
        check("midreset de flushed",  32'(snaps[kr + 5].de), 32'h0);
        check("midreset de resumes",  32'(snaps[kr + 6].de), 32'h1);
        cursor_phase(12'h000, "after reset");

        // Random counters, cursor placement, vsync edges and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            int h, v, ccol, crow;
            bit cen, r, vs;
            h   = int'($urandom_range(0, 1903));
            v   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(880, 931))
                                              : int'($urandom_range(0, 931));
            cen = bit'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                v = (v / 16) * 16 + int'($urandom_range(14, 15));
                if (v > 931) v = 931;
                ccol = h / 8;
                crow = (v / 16 > 55) ? 55 : v / 16;
            end else begin
                ccol = int'($urandom_range(0, 179));
                crow = int'($urandom_range(0, 55));
            end
            vs = ((v >= 901) && (v < 904)) || ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 299) == 0);
            step(r, h, v, (h < 1440) && (v < 900), !((h >= 1520) && (h < 1672)),
                 vs, cen, ccol, crow);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
